// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    StRun,
    StLoad,
    StDrain
  } imem_state_e;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous instruction array; the registered read is latency stage 1.
module imem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately not reset; a reset mid-load keeps what was written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory with fixed read latency and a boot-load word stream.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       imem_radd,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              oob_err,
  output logic              busy,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_done,
  output logic              ld_err
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("imem_responder: RD_LAT must be 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 15) begin : g_bad_addr
    $error("imem_responder: ADDR_W must be 1..15");
  end

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  imem_state_e       state_q, state_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              ld_err_q, ld_err_d;
  logic              load_done_q, load_done_d;
  logic              flush;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_last;
  logic              issue;
  logic              oob_in;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] oob_q;

  // Next-state logic for the RUN/LOAD/DRAIN controller and the write counter.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    ld_err_d    = ld_err_q;
    load_done_d = 1'b0;
    flush       = 1'b0;
    ram_we      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (load_start) begin
          state_d  = StLoad;
          wcnt_d   = '0;
          ld_err_d = 1'b0;
          flush    = 1'b1;
        end
      end
      StLoad: begin
        if (ld_valid) begin
          // wcnt MSB set means the counter has saturated at DEPTH: drop the word.
          if (!wcnt_q[ADDR_W]) begin
            ram_we = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
          end else begin
            ld_err_d = 1'b1;
          end
          if (ld_last) begin
            state_d = StDrain;
            dcnt_d  = '0;
          end
        end
      end
      StDrain: begin
        if (dcnt_q == DRAIN_LAST) begin
          state_d     = StRun;
          load_done_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      ld_err_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      dcnt_q      <= dcnt_d;
      ld_err_q    <= ld_err_d;
      load_done_q <= load_done_d;
    end
  end

  // The single RAM port belongs to the loader while in LOAD, to fetch otherwise.
  assign ram_addr = (state_q == StLoad) ? wcnt_q[ADDR_W-1:0] : imem_radd[ADDR_W-1:0];
  assign issue    = (state_q == StRun) && !load_start;
  assign oob_in   = |imem_radd[15:ADDR_W];

  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ld_data),
    .rdata_o(ram_rdata)
  );

  // Valid/oob tags travel alongside the read data; a flush kills everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      oob_q <= '0;
    end else begin
      vld_q[0] <= issue;
      oob_q[0] <= oob_in;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1] && !flush;
        oob_q[i] <= oob_q[i-1];
      end
    end
  end

  if (RD_LAT > 1) begin : g_dpipe
    logic [DATA_W-1:0] dat_q [RD_LAT-1];

    // Extra data stages beyond the RAM output register; qualified by vld_q.
    always_ff @(posedge clk) begin
      dat_q[0] <= ram_rdata;
      for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end

    assign rd_last = dat_q[RD_LAT-2];
  end else begin : g_nopipe
    assign rd_last = ram_rdata;
  end

  assign i_rvalid  = vld_q[RD_LAT-1];
  assign oob_err   = vld_q[RD_LAT-1] && oob_q[RD_LAT-1];
  assign i_rdata   = (vld_q[RD_LAT-1] && !oob_q[RD_LAT-1]) ? rd_last : NOP_WORD;
  assign busy      = (state_q != StRun);
  assign ld_ready  = (state_q == StLoad);
  assign load_done = load_done_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with RD_LAT = 3: load, read-back, flush, overflow, reset.
module tb_imem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int          LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       imem_radd;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              oob_err;
  logic              busy;
  logic              load_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              load_done;
  logic              ld_err;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (LAT),
    .NOP_WORD(16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_radd (imem_radd),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .oob_err   (oob_err),
    .busy      (busy),
    .load_start(load_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .load_done (load_done),
    .ld_err    (ld_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        oob;
  } rd_vec_t;

  rd_vec_t tbl[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic o);
    rd_vec_t v;
    v.addr = a;
    v.data = d;
    v.oob  = o;
    tbl.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk16({tag, " i_rdata"}, i_rdata, 16'h0000);
    chk1({tag, " i_rvalid"}, i_rvalid, 1'b0);
    chk1({tag, " oob_err"}, oob_err, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " ld_ready"}, ld_ready, 1'b0);
    chk1({tag, " load_done"}, load_done, 1'b0);
    chk1({tag, " ld_err"}, ld_err, 1'b0);
  endtask

  // Streams the table addresses back to back; result i is expected LAT cycles later.
  task automatic run_table(input string tag, input bit pre_empty, input bit done_first);
    int n;
    n = tbl.size();
    for (int i = 0; i < n + LAT; i++) begin
      chk1($sformatf("%s load_done[%0d]", tag, i), load_done, done_first && (i == 0));
      if (i >= LAT) begin
        chk16($sformatf("%s rdata[%0d]", tag, i - LAT), i_rdata, tbl[i-LAT].data);
        chk1($sformatf("%s rvalid[%0d]", tag, i - LAT), i_rvalid, 1'b1);
        chk1($sformatf("%s oob[%0d]", tag, i - LAT), oob_err, tbl[i-LAT].oob);
      end else if (pre_empty) begin
        chk1($sformatf("%s rvalid_pre[%0d]", tag, i), i_rvalid, 1'b0);
      end
      imem_radd = (i < n) ? tbl[i].addr : 16'h0000;
      tick();
    end
    tbl.delete();
  endtask

  task automatic start_load(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk1({tag, " busy@load"}, busy, 1'b1);
    chk1({tag, " ld_ready@load"}, ld_ready, 1'b1);
    chk1({tag, " rvalid@load"}, i_rvalid, 1'b0);
  endtask

  task automatic push_word(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    chk1("push ld_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Call in the first DRAIN cycle; returns in the first RUN cycle.
  task automatic drain_to_run(input string tag);
    for (int k = 0; k < LAT; k++) begin
      chk1($sformatf("%s drain busy[%0d]", tag, k), busy, 1'b1);
      chk1($sformatf("%s drain ld_ready[%0d]", tag, k), ld_ready, 1'b0);
      chk1($sformatf("%s drain load_done[%0d]", tag, k), load_done, 1'b0);
      chk1($sformatf("%s drain rvalid[%0d]", tag, k), i_rvalid, 1'b0);
      tick();
    end
    chk1({tag, " busy@run"}, busy, 1'b0);
    chk1({tag, " load_done@run"}, load_done, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_radd  = 16'h0000;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // Load four words, then read them back with some out-of-range probes.
    start_load("seqA");
    push_word(16'hA000, 1'b0);
    push_word(16'hA001, 1'b0);
    push_word(16'hA002, 1'b0);
    push_word(16'hA003, 1'b1);
    drain_to_run("seqA");
    add(16'h0000, 16'hA000, 1'b0);
    add(16'h0001, 16'hA001, 1'b0);
    add(16'h0002, 16'hA002, 1'b0);
    add(16'h0003, 16'hA003, 1'b0);
    add(16'h0100, 16'h0000, 1'b1);
    add(16'h0001, 16'hA001, 1'b0);
    add(16'hFF03, 16'h0000, 1'b1);
    add(16'h0003, 16'hA003, 1'b0);
    run_table("seqA", 1'b1, 1'b1);

    // Reads of 2 and 3 in flight when load_start arrives must never surface.
    imem_radd = 16'h0002;
    tick();
    imem_radd = 16'h0003;
    tick();
    load_start = 1'b1;
    chk1("flush rvalid before", i_rvalid, 1'b1);
    tick();
    load_start = 1'b0;
    chk1("flush busy", busy, 1'b1);
    chk1("flush rvalid c3", i_rvalid, 1'b0);
    chk16("flush rdata c3", i_rdata, 16'h0000);
    // Stalling loader: valid 1,0,1; the idle cycle carries junk with ld_last set.
    ld_valid = 1'b1; ld_data = 16'hB000; ld_last = 1'b0;
    tick();
    chk1("flush rvalid c4", i_rvalid, 1'b0);
    ld_valid = 1'b0; ld_data = 16'hBEEF; ld_last = 1'b1;
    chk1("stall ld_ready", ld_ready, 1'b1);
    tick();
    chk1("flush rvalid c5", i_rvalid, 1'b0);
    chk1("stall still load", ld_ready, 1'b1);
    ld_valid = 1'b1; ld_data = 16'hB001; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    drain_to_run("seqB");
    add(16'h0000, 16'hB000, 1'b0);
    add(16'h0001, 16'hB001, 1'b0);
    add(16'h0002, 16'hA002, 1'b0);
    add(16'h0003, 16'hA003, 1'b0);
    run_table("seqB", 1'b1, 1'b1);

    // Loader word with ld_last while in RUN is ignored.
    ld_valid = 1'b1; ld_data = 16'hCCCC; ld_last = 1'b1;
    chk1("run ld_ready", ld_ready, 1'b0);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk1("run stray busy", busy, 1'b0);
    add(16'h0000, 16'hB000, 1'b0);
    add(16'h0001, 16'hB001, 1'b0);
    run_table("seqD", 1'b0, 1'b0);

    // Overflow: DEPTH+1 words; the extra word is dropped and ld_err sticks.
    start_load("seqE");
    chk1("ovf ld_err start", ld_err, 1'b0);
    for (int i = 0; i < 256; i++) begin
      push_word(16'hD000 | 16'(i), 1'b0);
    end
    chk1("ovf ld_err at DEPTH", ld_err, 1'b0);
    push_word(16'hEEEE, 1'b1);
    chk1("ovf ld_err set", ld_err, 1'b1);
    drain_to_run("seqE");
    add(16'h0000, 16'hD000, 1'b0);
    add(16'h0001, 16'hD001, 1'b0);
    add(16'h00FF, 16'hD0FF, 1'b0);
    add(16'h0080, 16'hD080, 1'b0);
    run_table("seqE", 1'b1, 1'b1);
    chk1("ovf ld_err sticky", ld_err, 1'b1);

    // Next load clears ld_err; reset after two words leaves a partial image.
    start_load("seqF");
    chk1("ld_err cleared", ld_err, 1'b0);
    push_word(16'hF000, 1'b0);
    push_word(16'hF001, 1'b0);
    ld_valid = 1'b1; ld_data = 16'hF002; ld_last = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload");
    tick();
    ld_valid = 1'b0;
    check_reset_outputs("midload held");
    rst_n = 1'b1;
    chk1("post-reset busy", busy, 1'b0);
    add(16'h0001, 16'hF001, 1'b0);
    add(16'h0000, 16'hF000, 1'b0);
    add(16'h0002, 16'hD002, 1'b0);
    add(16'h0003, 16'hD003, 1'b0);
    run_table("seqF", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
